vectored_interrupt_controller: RTL

//  Multi-source, prioritised, vectored successor to the single-line interrupt controller in the RV32IMC fetch path.

---
 rtl/intc_pkg.sv | 19 +
 rtl/intc_prio_encoder.sv | 22 ++
 rtl/vectored_interrupt_controller.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/intc_pkg.sv
// Shared types and constants for the vectored interrupt controller.
package intc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARM,
        ST_TAKE,
        ST_RUN,
        ST_RET
    } intc_state_e;

    localparam logic [1:0]  EXE_CORR_NONE    = 2'b00;
    localparam logic [11:0] DEFAULT_VEC_BASE = 12'h800;

    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/intc_prio_encoder.sv
// Fixed-priority encoder: the lowest set index of eligible wins.
module intc_prio_encoder
    import intc_pkg::*;
#(
    parameter  int N_SRC = 4,
    localparam int ID_W  = id_width(N_SRC)
) (
    input  logic [N_SRC-1:0] eligible,
    output logic [ID_W-1:0]  winner,
    output logic             valid
);

    always_comb begin
        winner = '0;
        valid  = |eligible;
        // Scan downward so the lowest set index is the final assignment.
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (eligible[i]) winner = ID_W'(i);
        end
    end

endmodule

// File: rtl/vectored_interrupt_controller.sv
// Prioritised, vectored interrupt controller for the RV32IMC fetch path.
// Define INTC_NESTING_EN to allow preemption by higher-priority sources (NEST_DEPTH-deep PC stack).
module vectored_interrupt_controller
    import intc_pkg::*;
#(
    parameter  int              N_SRC      = 4,
    parameter  int              PC_W       = 12,
    parameter  logic [PC_W-1:0] VEC_BASE   = PC_W'(DEFAULT_VEC_BASE),
    parameter  int              VEC_STRIDE = 4,
    parameter  int              NEST_DEPTH = 4,
    localparam int              ID_W       = id_width(N_SRC)
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic [PC_W-1:0]   PC,
    input  logic [N_SRC-1:0]  irq_in,
    input  logic [N_SRC-1:0]  irq_mask,
    input  logic              if_ret,
    input  logic [1:0]        exe_correction,
    input  logic              if_prediction,
    input  logic              id_sel_pc,
    input  logic              if_clk_en,
    output logic              sel_ISR,
    output logic              ret_ISR,
    output logic              ISR_en,
    output logic              ISR_stall,
    output logic [PC_W-1:0]   save_PC,
    output logic [PC_W-1:0]   isr_addr,
    output logic [ID_W-1:0]   irq_id,
    output logic [N_SRC-1:0]  irq_ack,
    output intc_state_e       dbg_state
);

`ifdef INTC_NESTING_EN
    localparam bit NEST_EN = 1'b1;
`else
    localparam bit NEST_EN = 1'b0;
`endif
    localparam int DEPTH = NEST_EN ? NEST_DEPTH : 1;
    localparam int SP_W  = $clog2(DEPTH + 1);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    intc_state_e      state, state_next;
    logic [N_SRC-1:0] irq_prev, pending, eligible, rise;
    logic [ID_W-1:0]  winner;
    logic             valid, safe, can_take, take, do_ret;
    logic [SP_W-1:0]  sp, sp_next;
    logic [IDX_W-1:0] push_idx, below_idx;
    logic [PC_W-1:0]  pc_stack [DEPTH];
    logic [ID_W-1:0]  id_stack [DEPTH];

    assign rise      = irq_in & ~irq_prev;
    assign eligible  = pending & irq_mask;
    assign safe      = (exe_correction == EXE_CORR_NONE) && !if_prediction && !id_sel_pc && if_clk_en;
    // An empty stack takes anything; otherwise only a strictly higher priority source with room left.
    assign can_take  = valid && ((sp == '0) || ((sp < SP_W'(DEPTH)) && (winner < irq_id)));
    assign push_idx  = IDX_W'(sp);
    assign below_idx = IDX_W'(sp - SP_W'(2));
    assign dbg_state = state;

    intc_prio_encoder #(.N_SRC(N_SRC)) u_prio (
        .eligible (eligible),
        .winner   (winner),
        .valid    (valid)
    );

    always_ff @(posedge clk) begin
        if (!nrst) state <= ST_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        take       = 1'b0;
        do_ret     = 1'b0;
        sp_next    = sp;
        case (state)
            ST_IDLE: if (valid && !ISR_en) state_next = ST_ARM;
            ST_ARM: begin
                if (!can_take) begin
                    state_next = (sp != '0) ? ST_RUN : ST_IDLE;
                end else if (safe) begin
                    state_next = ST_TAKE;
                    take       = 1'b1;
                    sp_next    = sp + SP_W'(1);
                end
            end
            ST_TAKE: state_next = ST_RUN;
            ST_RUN: begin
                if (if_ret && if_clk_en) begin
                    state_next = ST_RET;
                    do_ret     = 1'b1;
                end else if (NEST_EN && can_take) begin
                    state_next = ST_ARM;
                end
            end
            ST_RET: begin
                sp_next    = sp - SP_W'(1);
                state_next = (sp == SP_W'(1)) ? ST_IDLE : ST_RUN;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            irq_prev  <= '0;
            pending   <= '0;
            sp        <= '0;
            sel_ISR   <= 1'b0;
            ret_ISR   <= 1'b0;
            ISR_en    <= 1'b0;
            ISR_stall <= 1'b0;
            save_PC   <= '0;
            isr_addr  <= '0;
            irq_id    <= '0;
            irq_ack   <= '0;
        end else begin
            irq_prev  <= irq_in;
            // A new edge in the ack cycle must survive the clear.
            pending   <= (pending & ~irq_ack) | rise;
            sp        <= sp_next;
            sel_ISR   <= take;
            ISR_stall <= take;
            ret_ISR   <= do_ret;
            ISR_en    <= (sp_next != '0);
            irq_ack   <= take ? (N_SRC'(1) << winner) : '0;
            if (take) begin
                pc_stack[push_idx] <= PC;
                id_stack[push_idx] <= winner;
                save_PC            <= PC;
                irq_id             <= winner;
                isr_addr           <= VEC_BASE + PC_W'(int'(winner) * VEC_STRIDE);
            end
            // Leaving RET with entries left: expose the interrupted ISR again.
            if (state == ST_RET && sp > SP_W'(1)) begin
                save_PC <= pc_stack[below_idx];
                irq_id  <= id_stack[below_idx];
            end
        end
    end

endmodule
